// File: rtl/mru_lookup_arbiter.sv
// Round-robin front end for a shared MRU value list.
// Serialises lookups, reports hit/evict results, sequences flushes and keeps hit/miss statistics.
module mru_lookup_arbiter #(
   parameter int DATA_W  = 8,
   parameter int NUM_REQ = 4,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk_in,
   input  logic                      reset_n_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   output logic                      rsp_valid_out,
   input  logic                      rsp_ready_in,
   output logic [ID_W-1:0]           rsp_id_out,
   output logic                      rsp_hit_out,
   output logic [IDX_W-1:0]          rsp_idx_out,
   output logic                      rsp_evict_valid_out,
   output logic [DATA_W-1:0]         rsp_evict_data_out,
   input  logic                      flush_in,
   output logic                      flush_busy_out,
   output logic [CNT_W-1:0]          hit_count_out,
   output logic [CNT_W-1:0]          miss_count_out
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t             state_reg;
   logic [DATA_W-1:0]  entry_reg [DEPTH];
   logic [DEPTH-1:0]   valid_reg;
   logic [ID_W-1:0]    ptr_reg;

   logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
   logic               grant_ok;
   logic               grant_any;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    ptr_next;
   logic               handshake;
   logic [DATA_W-1:0]  lookup_data;
   int                 scan_idx;
   logic               hit;
   logic [IDX_W-1:0]   hit_idx;
   logic               evict_valid;
   logic [DATA_W-1:0]  evict_data;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign req_data_arr[gi] = req_data_in[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Reset is folded in so no grant leaks out while reset_n_in is held low.
   assign grant_ok = reset_n_in && (state_reg == ST_RUN) && !flush_in &&
                     (!rsp_valid_out || rsp_ready_in);

   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan_idx  = 0;
      for (int o = 0; o < NUM_REQ; o++) begin
         scan_idx = int'(ptr_reg) + o;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!grant_any && req_valid_in[ID_W'(scan_idx)]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(scan_idx);
         end
      end
   end

   assign handshake     = grant_ok && grant_any;
   assign req_ready_out = handshake ? (NUM_REQ'(1) << grant_id) : '0;
   assign lookup_data   = req_data_arr[grant_id];
   assign ptr_next      = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

   // Lowest matching valid position wins; invalid slots never match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (!hit && valid_reg[k] && (entry_reg[k] == lookup_data)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

   assign evict_valid = !hit && valid_reg[DEPTH-1];
   assign evict_data  = evict_valid ? entry_reg[DEPTH-1] : '0;

   assign flush_busy_out = (state_reg == ST_FLUSH);

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_reg <= ST_RUN;
         valid_reg <= '0;
         ptr_reg   <= '0;
         for (int k = 0; k < DEPTH; k++) entry_reg[k] <= '0;
      end else begin
         case (state_reg)
            ST_RUN: if (flush_in) state_reg <= ST_FLUSH;
            ST_FLUSH: begin
               state_reg <= ST_RUN;
               valid_reg <= '0;
               for (int k = 0; k < DEPTH; k++) entry_reg[k] <= '0;
            end
         endcase
         // Handshakes only occur in RUN, so they never collide with the flush clear.
         if (handshake) begin
            ptr_reg      <= ptr_next;
            entry_reg[0] <= lookup_data;
            for (int j = 1; j < DEPTH; j++) begin
               if (!hit || (j <= int'(hit_idx))) entry_reg[j] <= entry_reg[j-1];
            end
            if (!hit) valid_reg <= {valid_reg[DEPTH-2:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         rsp_valid_out       <= 1'b0;
         rsp_id_out          <= '0;
         rsp_hit_out         <= 1'b0;
         rsp_idx_out         <= '0;
         rsp_evict_valid_out <= 1'b0;
         rsp_evict_data_out  <= '0;
         hit_count_out       <= '0;
         miss_count_out      <= '0;
      end else if (handshake) begin
         rsp_valid_out       <= 1'b1;
         rsp_id_out          <= grant_id;
         rsp_hit_out         <= hit;
         rsp_idx_out         <= hit_idx;
         rsp_evict_valid_out <= evict_valid;
         rsp_evict_data_out  <= evict_data;
         if (hit && (hit_count_out != '1))   hit_count_out  <= hit_count_out + 1'b1;
         if (!hit && (miss_count_out != '1)) miss_count_out <= miss_count_out + 1'b1;
      end else if (rsp_ready_in) begin
         rsp_valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mru_lookup_arbiter.sv
// Directed bench for mru_lookup_arbiter: lookup/evict, round-robin, backpressure, flush,
// counter saturation (second instance with CNT_W=2) and asynchronous reset.
`timescale 1ns/1ps
module tb_mru_lookup_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic        rsp_ready;
   logic        flush;

   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic        rsp_hit;
   logic [1:0]  rsp_idx;
   logic        rsp_evict_valid;
   logic [7:0]  rsp_evict_data;
   logic        flush_busy;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   logic [3:0]  s_req_ready;
   logic        s_rsp_valid;
   logic [1:0]  s_rsp_id;
   logic        s_rsp_hit;
   logic [1:0]  s_rsp_idx;
   logic        s_rsp_evict_valid;
   logic [7:0]  s_rsp_evict_data;
   logic        s_flush_busy;
   logic [1:0]  s_hit_count;
   logic [1:0]  s_miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mru_lookup_arbiter dut (
      .clk_in(clk), .reset_n_in(reset_n),
      .req_valid_in(req_valid), .req_data_in(req_data), .req_ready_out(req_ready),
      .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(rsp_id),
      .rsp_hit_out(rsp_hit), .rsp_idx_out(rsp_idx),
      .rsp_evict_valid_out(rsp_evict_valid), .rsp_evict_data_out(rsp_evict_data),
      .flush_in(flush), .flush_busy_out(flush_busy),
      .hit_count_out(hit_count), .miss_count_out(miss_count)
   );

   mru_lookup_arbiter #(.CNT_W(2)) dut_sat (
      .clk_in(clk), .reset_n_in(reset_n),
      .req_valid_in(req_valid), .req_data_in(req_data), .req_ready_out(s_req_ready),
      .rsp_valid_out(s_rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(s_rsp_id),
      .rsp_hit_out(s_rsp_hit), .rsp_idx_out(s_rsp_idx),
      .rsp_evict_valid_out(s_rsp_evict_valid), .rsp_evict_data_out(s_rsp_evict_data),
      .flush_in(flush), .flush_busy_out(s_flush_busy),
      .hit_count_out(s_hit_count), .miss_count_out(s_miss_count)
   );

   task automatic apply_reset();
      reset_n = 1'b0; req_valid = '0; flush = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Drives one lookup; returns at posedge+1 with the response registered.
   task automatic do_lookup(input int id, input logic [7:0] d);
      int waited;
      waited = 0;
      req_valid = '0; req_valid[id] = 1'b1; req_data[id*8 +: 8] = d;
      #1;
      while (req_ready[id] !== 1'b1 && waited < 20) begin
         @(posedge clk); #1; waited++;
      end
      n_tests++;
      if (req_ready[id] !== 1'b1) begin
         n_fail++; $display("FAIL grant_timeout req=%0d got ready=%b", id, req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      $display("[TB] lookup req=%0d data=%h -> valid=%b id=%0d hit=%b idx=%0d evict=%b/%h",
               id, d, rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_evict_valid, rsp_evict_data);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 4'hF; req_data = 32'hA3A2A1A0; rsp_ready = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk); #1;
      n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", req_ready); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_tests++; if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", flush_busy); end
      n_tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", hit_count, miss_count); end
      n_tests++; if (rsp_evict_data !== 8'h00 || rsp_idx !== 2'd0) begin
         n_fail++; $display("FAIL reset_fields got %h/%0d exp 0/0", rsp_evict_data, rsp_idx); end
      req_valid = '0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      $display("[TB] reset done");
   endtask

   task automatic test_zero_lookup();
      do_lookup(0, 8'h00);
      n_tests++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0) begin
         n_fail++; $display("FAIL zero_on_empty got valid=%b hit=%b exp 1/0", rsp_valid, rsp_hit); end
      n_tests++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL zero_miss_count got %0d exp 1", miss_count); end
      do_lookup(0, 8'h00);
      n_tests++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd0) begin
         n_fail++; $display("FAIL zero_rehit got hit=%b idx=%0d exp 1/0", rsp_hit, rsp_idx); end
   endtask

   task automatic test_fill();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         do_lookup(0, vals[i]);
         n_tests++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_evict_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_miss%0d got valid=%b hit=%b ev=%b exp 1/0/0", i, rsp_valid, rsp_hit, rsp_evict_valid); end
      end
      do_lookup(0, 8'h11);
      n_tests++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd3) begin
         n_fail++; $display("FAIL fill_hit11 got hit=%b idx=%0d exp 1/3", rsp_hit, rsp_idx); end
      do_lookup(0, 8'h22);
      n_tests++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd3) begin
         n_fail++; $display("FAIL fill_hit22_back got hit=%b idx=%0d exp 1/3", rsp_hit, rsp_idx); end
      do_lookup(0, 8'h22);
      n_tests++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd0) begin
         n_fail++; $display("FAIL fill_b2b_front got hit=%b idx=%0d exp 1/0", rsp_hit, rsp_idx); end
      n_tests++; if (hit_count !== 16'd3 || miss_count !== 16'd4) begin
         n_fail++; $display("FAIL fill_counts got %0d/%0d exp 3/4", hit_count, miss_count); end
      n_tests++; if (s_hit_count !== 2'd3 || s_miss_count !== 2'd3) begin
         n_fail++; $display("FAIL fill_sat_counts got %0d/%0d exp 3/3", s_hit_count, s_miss_count); end
   endtask

   task automatic test_evict();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      n_tests++; if (flush_busy !== 1'b1) begin n_fail++; $display("FAIL evict_flush_busy got %b exp 1", flush_busy); end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         do_lookup(0, vals[i]);
         n_tests++; if (rsp_hit !== 1'b0 || rsp_evict_valid !== 1'b0) begin
            n_fail++; $display("FAIL evict_refill%0d got hit=%b ev=%b exp 0/0", i, rsp_hit, rsp_evict_valid); end
      end
      do_lookup(0, 8'h55);
      n_tests++; if (rsp_hit !== 1'b0 || rsp_evict_valid !== 1'b1 || rsp_evict_data !== 8'h11) begin
         n_fail++; $display("FAIL evict_55 got hit=%b ev=%b data=%h exp 0/1/11", rsp_hit, rsp_evict_valid, rsp_evict_data); end
      n_tests++; if (hit_count !== 16'd3 || miss_count !== 16'd9) begin
         n_fail++; $display("FAIL evict_counts got %0d/%0d exp 3/9", hit_count, miss_count); end
   endtask

   task automatic test_round_robin();
      rsp_ready = 1'b1; req_data = 32'hA3A2A1A0; req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_tests++; if (req_ready !== (4'b0001 << (k % 4))) begin
            n_fail++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
         @(posedge clk); #1;
         $display("[TB] rr cycle=%0d id=%0d hit=%b idx=%0d", k, rsp_id, rsp_hit, rsp_idx);
         n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin
            n_fail++; $display("FAIL rr_rsp_id%0d got valid=%b id=%0d exp 1/%0d", k, rsp_valid, rsp_id, k % 4); end
         n_tests++; if (rsp_hit !== (k >= 4) || rsp_idx !== ((k >= 4) ? 2'd3 : 2'd0)) begin
            n_fail++; $display("FAIL rr_hit%0d got hit=%b idx=%0d exp %b/%0d", k, rsp_hit, rsp_idx, k >= 4, (k >= 4) ? 3 : 0); end
      end
      req_valid = '0;
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got valid=%b exp 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'hB1;
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant got %b exp 0010", req_ready); end
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_evict_valid !== 1'b1 || rsp_evict_data !== 8'hA0) begin
         n_fail++; $display("FAIL bp_load got v=%b id=%0d ev=%b/%h exp 1/1/1/a0", rsp_valid, rsp_id, rsp_evict_valid, rsp_evict_data); end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b exp 0000", i, req_ready); end
         n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_hit !== 1'b0 || rsp_evict_data !== 8'hA0) begin
            n_fail++; $display("FAIL bp_hold%0d got v=%b id=%0d hit=%b ev=%h exp 1/1/0/a0", i, rsp_valid, rsp_id, rsp_hit, rsp_evict_data); end
         n_tests++; if (hit_count !== 16'd4 || miss_count !== 16'd5) begin
            n_fail++; $display("FAIL bp_counts%0d got %0d/%0d exp 4/5", i, hit_count, miss_count); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume got %b exp 0010", req_ready); end
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_idx !== 2'd0 || hit_count !== 16'd5) begin
         n_fail++; $display("FAIL bp_after got v=%b hit=%b idx=%0d hc=%0d exp 1/1/0/5", rsp_valid, rsp_hit, rsp_idx, hit_count); end
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      rsp_ready = 1'b0; req_valid = 4'b0100; req_data[23:16] = 8'hA2;
      @(posedge clk); #1;
      req_valid = '0;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_hit !== 1'b1 || rsp_idx !== 2'd2) begin
         n_fail++; $display("FAIL fl_pending got v=%b id=%0d hit=%b idx=%0d exp 1/2/1/2", rsp_valid, rsp_id, rsp_hit, rsp_idx); end
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      n_tests++; if (flush_busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_idx !== 2'd2) begin
         n_fail++; $display("FAIL fl_busy got busy=%b v=%b idx=%0d exp 1/1/2", flush_busy, rsp_valid, rsp_idx); end
      @(posedge clk); #1;
      n_tests++; if (flush_busy !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_hit !== 1'b1) begin
         n_fail++; $display("FAIL fl_preserved got busy=%b v=%b id=%0d hit=%b exp 0/1/2/1", flush_busy, rsp_valid, rsp_id, rsp_hit); end
      rsp_ready = 1'b1; req_valid = 4'b0100;
      #1;
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fl_resume got %b exp 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_evict_valid !== 1'b0) begin
         n_fail++; $display("FAIL fl_miss got v=%b hit=%b ev=%b exp 1/0/0", rsp_valid, rsp_hit, rsp_evict_valid); end
      n_tests++; if (hit_count !== 16'd6 || miss_count !== 16'd6) begin
         n_fail++; $display("FAIL fl_counts got %0d/%0d exp 6/6", hit_count, miss_count); end
   endtask

   task automatic test_saturation();
      do_lookup(0, 8'h77);
      for (int i = 1; i <= 5; i++) begin
         do_lookup(0, 8'h77);
         n_tests++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd0) begin
            n_fail++; $display("FAIL sat_hit%0d got hit=%b idx=%0d exp 1/0", i, rsp_hit, rsp_idx); end
         n_tests++; if (s_hit_count !== 2'((i > 3) ? 3 : i) || hit_count !== 16'(i)) begin
            n_fail++; $display("FAIL sat_count%0d got %0d/%0d exp %0d/%0d", i, s_hit_count, hit_count, (i > 3) ? 3 : i, i); end
      end
      req_valid = 4'b0001;
      reset_n = 1'b0;
      #1;
      n_tests++; if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_idx !== 2'd0 || rsp_id !== 2'd0 || rsp_evict_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_rsp got v=%b hit=%b idx=%0d id=%0d ev=%b exp all 0", rsp_valid, rsp_hit, rsp_idx, rsp_id, rsp_evict_valid); end
      n_tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0 || s_hit_count !== 2'd0) begin
         n_fail++; $display("FAIL midrst_counts got %0d/%0d/%0d exp 0/0/0", hit_count, miss_count, s_hit_count); end
      n_tests++; if (req_ready !== 4'b0000 || flush_busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ready got %b busy=%b exp 0000/0", req_ready, flush_busy); end
      @(negedge clk); reset_n = 1'b1;
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant got %b exp 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0) begin
         n_fail++; $display("FAIL midrst_list_cleared got v=%b hit=%b exp 1/0", rsp_valid, rsp_hit); end
   endtask

   initial begin
      test_reset();
      test_zero_lookup();
      apply_reset();
      test_fill();
      test_evict();
      apply_reset();
      test_round_robin();
      test_backpressure();
      test_flush();
      apply_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

endmodule
